// File: rtl/rv32i_pkg.sv
// RV32I decode definitions shared by fetch, decode and execute: opcodes, op indices, immediate formats.
// The op index is the single encoding execute dispatches on; OP_ILLEGAL must stay at 0.
package rv32i_pkg;

    localparam int OP_IDX_W = 6;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [OP_IDX_W-1:0] {
        OP_ILLEGAL = 6'd0,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
    } op_e;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_e;

    typedef struct packed {
        op_e        op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rs1_valid;
        logic       rs2_valid;
        logic       rd_we;
        logic       illegal;
    } dec_t;

    function automatic logic [31:0] imm32(input imm_e t, input logic [31:0] ins);
        case (t)
            IMM_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm32 = {ins[31:12], 12'b0};
            IMM_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_decode_comb.sv
// Pure combinational RV32I decoder: instruction word -> op index, register specifiers, immediate.
// Illegal encodings return an all-zero entry with only the illegal flag set.
module rv32i_decode_comb #(
    parameter int XLEN = 32
) (
    input  logic [31:0]              i_instr,
    output rv32i_pkg::dec_t          o_dec,
    output logic [XLEN-1:0]          o_imm
);
    import rv32i_pkg::*;

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    op_e        w_op;
    imm_e       w_imm_t;
    logic       w_use1;
    logic       w_use2;
    logic       w_used;
    logic       w_ill;

    assign w_opc = i_instr[6:0];
    assign w_f3  = i_instr[14:12];
    assign w_f7  = i_instr[31:25];
    assign w_ill = (w_op == OP_ILLEGAL);

    always_comb begin
        w_op    = OP_ILLEGAL;
        w_imm_t = IMM_NONE;
        w_use1  = 1'b0;
        w_use2  = 1'b0;
        w_used  = 1'b0;
        case (w_opc)
            OPC_OP: begin
                w_use1 = 1'b1; w_use2 = 1'b1; w_used = 1'b1;
                if (w_f7 == 7'h00) begin
                    case (w_f3)
                        3'd0: w_op = OP_ADD;  3'd1: w_op = OP_SLL;
                        3'd2: w_op = OP_SLT;  3'd3: w_op = OP_SLTU;
                        3'd4: w_op = OP_XOR;  3'd5: w_op = OP_SRL;
                        3'd6: w_op = OP_OR;   default: w_op = OP_AND;
                    endcase
                end else if (w_f7 == 7'h20) begin
                    if (w_f3 == 3'd0)      w_op = OP_SUB;
                    else if (w_f3 == 3'd5) w_op = OP_SRA;
                end
            end
            OPC_OP_IMM: begin
                w_use1 = 1'b1; w_used = 1'b1; w_imm_t = IMM_I;
                case (w_f3)
                    3'd0: w_op = OP_ADDI;  3'd2: w_op = OP_SLTI;
                    3'd3: w_op = OP_SLTIU; 3'd4: w_op = OP_XORI;
                    3'd6: w_op = OP_ORI;   3'd7: w_op = OP_ANDI;
                    3'd1: w_op = (w_f7 == 7'h00) ? OP_SLLI : OP_ILLEGAL;
                    default: w_op = (w_f7 == 7'h00) ? OP_SRLI :
                                    (w_f7 == 7'h20) ? OP_SRAI : OP_ILLEGAL;
                endcase
            end
            OPC_LOAD: begin
                w_use1 = 1'b1; w_used = 1'b1; w_imm_t = IMM_I;
                case (w_f3)
                    3'd0: w_op = OP_LB;  3'd1: w_op = OP_LH;  3'd2: w_op = OP_LW;
                    3'd4: w_op = OP_LBU; 3'd5: w_op = OP_LHU; default: w_op = OP_ILLEGAL;
                endcase
            end
            OPC_STORE: begin
                w_use1 = 1'b1; w_use2 = 1'b1; w_imm_t = IMM_S;
                case (w_f3)
                    3'd0: w_op = OP_SB; 3'd1: w_op = OP_SH; 3'd2: w_op = OP_SW;
                    default: w_op = OP_ILLEGAL;
                endcase
            end
            OPC_BRANCH: begin
                w_use1 = 1'b1; w_use2 = 1'b1; w_imm_t = IMM_B;
                case (w_f3)
                    3'd0: w_op = OP_BEQ;  3'd1: w_op = OP_BNE;
                    3'd4: w_op = OP_BLT;  3'd5: w_op = OP_BGE;
                    3'd6: w_op = OP_BLTU; 3'd7: w_op = OP_BGEU;
                    default: w_op = OP_ILLEGAL;
                endcase
            end
            OPC_JAL:   begin w_used = 1'b1; w_imm_t = IMM_J; w_op = OP_JAL; end
            OPC_JALR: begin
                w_use1 = 1'b1; w_used = 1'b1; w_imm_t = IMM_I;
                w_op = (w_f3 == 3'd0) ? OP_JALR : OP_ILLEGAL;
            end
            OPC_LUI:   begin w_used = 1'b1; w_imm_t = IMM_U; w_op = OP_LUI; end
            OPC_AUIPC: begin w_used = 1'b1; w_imm_t = IMM_U; w_op = OP_AUIPC; end
            default: ;
        endcase
    end

    // Unused specifiers read as 0 so hazard logic never matches a phantom register.
    always_comb begin
        o_dec         = '0;
        o_dec.op      = w_op;
        o_dec.illegal = w_ill;
        if (!w_ill) begin
            o_dec.rs1       = w_use1 ? i_instr[19:15] : 5'd0;
            o_dec.rs2       = w_use2 ? i_instr[24:20] : 5'd0;
            o_dec.rd        = w_used ? i_instr[11:7]  : 5'd0;
            o_dec.rs1_valid = w_use1;
            o_dec.rs2_valid = w_use2;
            o_dec.rd_we     = w_used && (i_instr[11:7] != 5'd0);
        end
    end

    assign o_imm = w_ill ? '0 : XLEN'($signed(imm32(w_imm_t, i_instr)));

endmodule

// File: rtl/rv32i_decode_stage.sv
// Registered RV32I decode stage: decodes on accept and buffers entries in a DEPTH-deep FIFO.
// One-cycle latency; in_ready depends only on occupancy, flush empties the FIFO and drops same-cycle traffic.
module rv32i_decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int OP_W  = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [XLEN-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [OP_W-1:0]          out_op,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [4:0]               out_rd,
    output logic                     out_rs1_valid,
    output logic                     out_rs2_valid,
    output logic                     out_rd_we,
    output logic [XLEN-1:0]          out_imm,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count
);
    import rv32i_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    dec_t             w_dec;
    dec_t             w_head;
    logic [XLEN-1:0]  w_imm;
    logic             w_push;
    logic             w_pop;

    dec_t             r_dec [DEPTH];
    logic [XLEN-1:0]  r_imm [DEPTH];
    logic [XLEN-1:0]  r_pc  [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    rv32i_decode_comb #(.XLEN(XLEN)) u_dec (
        .i_instr (in_instr),
        .o_dec   (w_dec),
        .o_imm   (w_imm)
    );

    assign in_ready  = (r_count < CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign count     = r_count;

    // Storage is cleared on reset so the head reads as all-zero until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_dec[i] <= '0;
                r_imm[i] <= '0;
                r_pc[i]  <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_dec[r_wr_ptr] <= w_dec;
                r_imm[r_wr_ptr] <= w_imm;
                r_pc[r_wr_ptr]  <= in_pc;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    assign w_head        = r_dec[r_rd_ptr];
    assign out_pc        = r_pc[r_rd_ptr];
    assign out_imm       = r_imm[r_rd_ptr];
    assign out_op        = OP_W'(w_head.op);
    assign out_rs1       = w_head.rs1;
    assign out_rs2       = w_head.rs2;
    assign out_rd        = w_head.rd;
    assign out_rs1_valid = w_head.rs1_valid;
    assign out_rs2_valid = w_head.rs2_valid;
    assign out_rd_we     = w_head.rd_we;
    assign out_illegal   = w_head.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Directed bench for rv32i_decode_stage: decode vector table plus FIFO full/flush/reset sequences.
module tb_rv32i_decode_stage;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [5:0]  out_op;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_rs1_valid, out_rs2_valid, out_rd_we, out_illegal;
    logic [1:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    rv32i_decode_stage #(.XLEN(32), .DEPTH(2), .OP_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_rs1_valid(out_rs1_valid), .out_rs2_valid(out_rs2_valid),
        .out_rd_we(out_rd_we), .out_imm(out_imm), .out_illegal(out_illegal), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        op_e         op;
        logic [4:0]  rs1, rs2, rd;
        logic        rs1v, rs2v, rdwe, ill;
        logic [31:0] imm;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [1:0] c, input logic v, input logic r);
        chk({tag, ".count"},     32'(count),     32'(c));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(r));
    endtask

    initial begin
        //              instr          op          rs1 rs2 rd  r1v r2v we ill imm
        vecs[0]  = '{32'hFFF10093, OP_ADDI,    5'd2, 5'd0, 5'd1,  1, 0, 1, 0, 32'hFFFFFFFF};
        vecs[1]  = '{32'hFE000EE3, OP_BEQ,     5'd0, 5'd0, 5'd0,  1, 1, 0, 0, 32'hFFFFFFFC};
        vecs[2]  = '{32'h00312423, OP_SW,      5'd2, 5'd3, 5'd0,  1, 1, 0, 0, 32'h00000008};
        vecs[3]  = '{32'h123452B7, OP_LUI,     5'd0, 5'd0, 5'd5,  0, 0, 1, 0, 32'h12345000};
        vecs[4]  = '{32'h00000000, OP_ILLEGAL, 5'd0, 5'd0, 5'd0,  0, 0, 0, 1, 32'h00000000};
        vecs[5]  = '{32'h407302B3, OP_SUB,     5'd6, 5'd7, 5'd5,  1, 1, 1, 0, 32'h00000000};
        vecs[6]  = '{32'h4030D093, OP_SRAI,    5'd1, 5'd0, 5'd1,  1, 0, 1, 0, 32'h00000403};
        vecs[7]  = '{32'h40309093, OP_ILLEGAL, 5'd0, 5'd0, 5'd0,  0, 0, 0, 1, 32'h00000000};
        vecs[8]  = '{32'h008000EF, OP_JAL,     5'd0, 5'd0, 5'd1,  0, 0, 1, 0, 32'h00000008};
        vecs[9]  = '{32'h000110E7, OP_ILLEGAL, 5'd0, 5'd0, 5'd0,  0, 0, 0, 1, 32'h00000000};
        vecs[10] = '{32'hFFFFF517, OP_AUIPC,   5'd0, 5'd0, 5'd10, 0, 0, 1, 0, 32'hFFFFF000};
        vecs[11] = '{32'hFFC0A003, OP_LW,      5'd1, 5'd0, 5'd0,  1, 0, 0, 0, 32'hFFFFFFFC};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'd0; in_pc = 32'd0;
        #12;
        chk_state("reset", 2'd0, 1'b0, 1'b1);
        chk("reset.out_op",  32'(out_op), 32'd0);
        chk("reset.out_imm", out_imm,     32'd0);
        chk("reset.out_pc",  out_pc,      32'd0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = 32'h1000 + 32'(i * 4); out_ready = 1'b0;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d.valid", i), 32'(out_valid),     32'd1);
            chk($sformatf("v%0d.pc", i),    out_pc,             32'h1000 + 32'(i * 4));
            chk($sformatf("v%0d.op", i),    32'(out_op),        32'(vecs[i].op));
            chk($sformatf("v%0d.rs1", i),   32'(out_rs1),       32'(vecs[i].rs1));
            chk($sformatf("v%0d.rs2", i),   32'(out_rs2),       32'(vecs[i].rs2));
            chk($sformatf("v%0d.rd", i),    32'(out_rd),        32'(vecs[i].rd));
            chk($sformatf("v%0d.rs1v", i),  32'(out_rs1_valid), 32'(vecs[i].rs1v));
            chk($sformatf("v%0d.rs2v", i),  32'(out_rs2_valid), 32'(vecs[i].rs2v));
            chk($sformatf("v%0d.rd_we", i), 32'(out_rd_we),     32'(vecs[i].rdwe));
            chk($sformatf("v%0d.ill", i),   32'(out_illegal),   32'(vecs[i].ill));
            chk($sformatf("v%0d.imm", i),   out_imm,            vecs[i].imm);
            out_ready = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk_state("drain", 2'd0, 1'b0, 1'b1);

        // Fill with out_ready low: third push must be held off.
        in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'h100;
        @(negedge clk); in_pc = 32'h104;
        @(negedge clk);
        chk_state("full", 2'd2, 1'b1, 1'b0);
        in_pc = 32'h108;
        @(negedge clk);
        chk_state("full_hold", 2'd2, 1'b1, 1'b0);
        chk("full_hold.pc", out_pc, 32'h100);
        out_ready = 1'b1;
        @(negedge clk);
        chk_state("pop1", 2'd1, 1'b1, 1'b1);
        chk("pop1.pc", out_pc, 32'h104);
        @(negedge clk);
        in_valid = 1'b0;
        chk_state("pushpop", 2'd1, 1'b1, 1'b1);
        chk("pushpop.pc", out_pc, 32'h108);
        @(negedge clk);
        chk_state("empty", 2'd0, 1'b0, 1'b1);

        // Flush while full with a same-cycle push and pop.
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h200;
        @(negedge clk); in_pc = 32'h204;
        @(negedge clk);
        chk_state("pre_flush", 2'd2, 1'b1, 1'b0);
        flush = 1'b1; out_ready = 1'b1; in_pc = 32'h208;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk_state("flush", 2'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk_state("post_flush", 2'd0, 1'b0, 1'b1);

        // Async reset with one entry buffered.
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h300;
        @(negedge clk);
        in_valid = 1'b0;
        chk_state("pre_rst", 2'd1, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_state("async_rst", 2'd0, 1'b0, 1'b1);
        chk("async_rst.out_pc", out_pc, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk_state("after_rst", 2'd0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
